bitslice_pwr_seq: RTL and testbench

//  Power-gating sequencer driving the bit_slice low-power control inputs:

---
 rtl/bitslice_pwr_seq_if.sv | 30 +++
 rtl/bitslice_pwr_seq.sv | 164 ++++++++++++++++
 tb/tb_bitslice_pwr_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitslice_pwr_seq_if.sv
// Request, ack and low-power control bundle between the power sequencer and bit_slice.
// master = sequencer side, slave = slice side.
interface bitslice_pwr_seq_if #(
    parameter int NUM_DOM = 4
);
    logic               pwr_down_req;
    logic               pwr_up_req;
    logic               data_valid;
    logic [NUM_DOM-1:0] PG_ack_signals;
    logic               memory_ack;
    logic [NUM_DOM-1:0] isolation_signals;
    logic [NUM_DOM-1:0] retention_signals;
    logic [NUM_DOM-1:0] shut_down_signals;
    logic               memory_sleep;
    logic               busy;
    logic               pwr_off;
    logic               err;

    modport master (
        input  pwr_down_req, pwr_up_req, data_valid, PG_ack_signals, memory_ack,
        output isolation_signals, retention_signals, shut_down_signals,
        output memory_sleep, busy, pwr_off, err
    );

    modport slave (
        output pwr_down_req, pwr_up_req, data_valid, PG_ack_signals, memory_ack,
        input  isolation_signals, retention_signals, shut_down_signals,
        input  memory_sleep, busy, pwr_off, err
    );
endinterface

// File: rtl/bitslice_pwr_seq.sv
// Power-gating sequencer for bit_slice: orders isolation, retention, switch-off and
// memory sleep around single-cycle down/up requests, with ack timeouts into a sticky error.
module bitslice_pwr_seq #(
    parameter int NUM_DOM = 4,
    parameter int ISO_CYC = 4,
    parameter int RET_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               hclk,
    input  logic               reset,
    bitslice_pwr_seq_if.master bus
);

    localparam int CNT_MAX = (TIMEOUT > ISO_CYC) ?
                             ((TIMEOUT > RET_CYC) ? TIMEOUT : RET_CYC) :
                             ((ISO_CYC > RET_CYC) ? ISO_CYC : RET_CYC);
    localparam int CW = $clog2(CNT_MAX) + 1;

    typedef enum logic [3:0] {
        S_ON, S_ISO, S_SAVE, S_PDN, S_MSLP, S_OFF,
        S_MWAKE, S_PUP, S_REST, S_DISO, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iso_q, iso_d;
    logic          ret_q, ret_d;
    logic          shut_q, shut_d;
    logic          msl_q, msl_d;
    logic          busy_q, busy_d;
    logic          off_q, off_d;
    logic          err_q, err_d;

    logic pg_all_on;
    logic pg_all_off;
    logic timeout_hit;

    assign pg_all_on   = &bus.PG_ack_signals;
    assign pg_all_off  = ~|bus.PG_ack_signals;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Next state; the ack test precedes the timeout test so a last-cycle ack wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            S_ON: begin
                cnt_d = '0;
                if (bus.pwr_down_req && !bus.data_valid) state_d = S_ISO;
            end
            S_ISO:   if (cnt_q == CW'(ISO_CYC - 1)) state_d = S_SAVE;
            S_SAVE:  if (cnt_q == CW'(RET_CYC - 1)) state_d = S_PDN;
            S_PDN: begin
                if (pg_all_on)        state_d = S_MSLP;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_MSLP: begin
                if (bus.memory_ack)   state_d = S_OFF;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_OFF: begin
                cnt_d = '0;
                if (bus.pwr_up_req) state_d = S_MWAKE;
            end
            S_MWAKE: begin
                if (!bus.memory_ack)  state_d = S_PUP;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_PUP: begin
                if (pg_all_off)       state_d = S_REST;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_REST:  if (cnt_q == CW'(RET_CYC - 1)) state_d = S_DISO;
            S_DISO:  if (cnt_q == CW'(ISO_CYC - 1)) state_d = S_ON;
            S_ERR:   cnt_d = cnt_q;
            default: state_d = S_ON;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Output levels are a function of the state being entered, so they move on the entry edge.
    always_comb begin
        iso_d  = 1'b0;
        ret_d  = 1'b0;
        shut_d = 1'b0;
        msl_d  = 1'b0;
        busy_d = 1'b1;
        off_d  = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            S_ON:                  busy_d = 1'b0;
            S_ISO, S_REST, S_DISO: iso_d  = 1'b1;
            S_SAVE, S_PUP: begin
                iso_d = 1'b1;
                ret_d = 1'b1;
            end
            S_PDN, S_MWAKE: begin
                iso_d  = 1'b1;
                ret_d  = 1'b1;
                shut_d = 1'b1;
            end
            S_MSLP: begin
                iso_d  = 1'b1;
                ret_d  = 1'b1;
                shut_d = 1'b1;
                msl_d  = 1'b1;
            end
            S_OFF: begin
                iso_d  = 1'b1;
                ret_d  = 1'b1;
                shut_d = 1'b1;
                msl_d  = 1'b1;
                off_d  = 1'b1;
                busy_d = 1'b0;
            end
            S_ERR: begin
                iso_d  = iso_q;
                ret_d  = ret_q;
                shut_d = shut_q;
                msl_d  = msl_q;
                off_d  = off_q;
                err_d  = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            state_q <= S_ON;
            cnt_q   <= '0;
            iso_q   <= 1'b0;
            ret_q   <= 1'b0;
            shut_q  <= 1'b0;
            msl_q   <= 1'b0;
            busy_q  <= 1'b0;
            off_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iso_q   <= iso_d;
            ret_q   <= ret_d;
            shut_q  <= shut_d;
            msl_q   <= msl_d;
            busy_q  <= busy_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    // All domains are sequenced together, so each vector is one register fanned out.
    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
        assign bus.isolation_signals[gi] = iso_q;
        assign bus.retention_signals[gi] = ret_q;
        assign bus.shut_down_signals[gi] = shut_q;
    end

    assign bus.memory_sleep = msl_q;
    assign bus.busy         = busy_q;
    assign bus.pwr_off      = off_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_bitslice_pwr_seq.sv
// Bench for bitslice_pwr_seq: expected outputs come from a timeline of milestone edges
// computed from the sequencing rules and the randomly chosen ack delays.
module tb_bitslice_pwr_seq;

    localparam int NUM_DOM = 4;
    localparam int ISO_CYC = 4;
    localparam int RET_CYC = 2;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000000;
    localparam int OW      = 3 * NUM_DOM + 4;

    logic hclk = 1'b0;
    logic reset;
    always #5 hclk = ~hclk;

    bitslice_pwr_seq_if #(.NUM_DOM(NUM_DOM)) bus ();

    bitslice_pwr_seq #(
        .NUM_DOM(NUM_DOM),
        .ISO_CYC(ISO_CYC),
        .RET_CYC(RET_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .hclk (hclk),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct {
        int edge_n;
        bit iso, ret, shut, msl, busy, off, err;
    } mile_t;

    mile_t tl[$];
    int    cyc;
    int    tests;
    int    fails;
    int    end_edge;
    int    down_edge, up_edge;
    int    pg_on, pg_off, mem_on, mem_off;
    bit    dv_at_down;
    bit    force_up_at_down;
    logic [NUM_DOM-1:0] pg_low;
    string tag;

    task automatic mile(input int e, input bit iso, input bit ret, input bit shut,
                        input bit msl, input bit busy, input bit off, input bit err);
        mile_t m;
        m.edge_n = e; m.iso = iso; m.ret = ret; m.shut = shut;
        m.msl = msl; m.busy = busy; m.off = off; m.err = err;
        tl.push_back(m);
    endtask

    function automatic mile_t expect_at(input int e);
        mile_t m;
        m = tl[0];
        foreach (tl[i]) if (tl[i].edge_n <= e) m = tl[i];
        return m;
    endfunction

    task automatic check();
        mile_t m;
        logic [OW-1:0] obs;
        logic [OW-1:0] exp_v;
        m = expect_at(cyc);
        obs = {bus.isolation_signals, bus.retention_signals, bus.shut_down_signals,
               bus.memory_sleep, bus.busy, bus.pwr_off, bus.err};
        exp_v = {{NUM_DOM{m.iso}}, {NUM_DOM{m.ret}}, {NUM_DOM{m.shut}},
                 m.msl, m.busy, m.off, m.err};
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s cyc=%0d iso|ret|shut|msl|busy|off|err observed=%b expected=%b",
                   tag, cyc, obs, exp_v);
        end
        $display("[TB] %s cyc=%0d outputs=%b", tag, cyc, obs);
    endtask

    // Inputs for the next rising edge; random requests only where they must be ignored.
    task automatic drive_next();
        int    n;
        mile_t m;
        n = cyc + 1;
        m = expect_at(cyc);
        bus.pwr_down_req = (n == down_edge);
        bus.pwr_up_req   = (n == up_edge) || (force_up_at_down && n == down_edge);
        bus.data_valid   = (n == down_edge) ? dv_at_down : 1'($urandom_range(0, 1));
        if (m.busy) begin
            bus.pwr_down_req = bus.pwr_down_req | ($urandom_range(0, 3) == 0);
            bus.pwr_up_req   = bus.pwr_up_req   | ($urandom_range(0, 3) == 0);
        end else if (m.off) begin
            bus.pwr_down_req = bus.pwr_down_req | ($urandom_range(0, 2) == 0);
        end
        bus.PG_ack_signals = (n >= pg_on && n < pg_off) ? {NUM_DOM{1'b1}} : pg_low;
        bus.memory_ack     = (n >= mem_on && n < mem_off);
    endtask

    task automatic step();
        drive_next();
        @(posedge hclk);
        cyc++;
        @(negedge hclk);
        check();
    endtask

    task automatic run_to_end(input int extra);
        end_edge = end_edge + extra;
        while (cyc < end_edge) step();
    endtask

    // Down sequence with PG ack a cycles after PDN entry and memory ack b cycles after MSLP entry.
    task automatic plan_down(input int a, input int b);
        int r, p, m;
        r = cyc + 1;
        down_edge = r;
        dv_at_down = 1'b0;
        p = r + ISO_CYC + RET_CYC;
        mile(r,           1, 0, 0, 0, 1, 0, 0);
        mile(r + ISO_CYC, 1, 1, 0, 0, 1, 0, 0);
        mile(p,           1, 1, 1, 0, 1, 0, 0);
        pg_on = p + a; pg_off = NEVER;
        mem_on = NEVER; mem_off = NEVER;
        if (a <= TIMEOUT) begin
            m = p + a;
            mile(m, 1, 1, 1, 1, 1, 0, 0);
            mem_on = m + b;
            if (b <= TIMEOUT) begin
                mile(m + b, 1, 1, 1, 1, 0, 1, 0);
                end_edge = m + b;
            end else begin
                mile(m + TIMEOUT, 1, 1, 1, 1, 1, 0, 1);
                end_edge = m + TIMEOUT;
            end
        end else begin
            mile(p + TIMEOUT, 1, 1, 1, 0, 1, 0, 1);
            end_edge = p + TIMEOUT;
        end
    endtask

    // Up sequence from OFF: memory ack drops c cycles after MWAKE, PG acks d cycles after PUP.
    task automatic plan_up(input int c, input int d);
        int u, pu, rs;
        u = cyc + 1;
        up_edge = u;
        mile(u, 1, 1, 1, 0, 1, 0, 0);
        mem_off = u + c;
        if (c <= TIMEOUT) begin
            pu = u + c;
            mile(pu, 1, 1, 0, 0, 1, 0, 0);
            pg_off = pu + d;
            if (d <= TIMEOUT) begin
                rs = pu + d;
                mile(rs, 1, 0, 0, 0, 1, 0, 0);
                mile(rs + RET_CYC + ISO_CYC, 0, 0, 0, 0, 0, 0, 0);
                end_edge = rs + RET_CYC + ISO_CYC;
            end else begin
                mile(pu + TIMEOUT, 1, 1, 0, 0, 1, 0, 1);
                end_edge = pu + TIMEOUT;
            end
        end else begin
            mile(u + TIMEOUT, 1, 1, 1, 0, 1, 0, 1);
            end_edge = u + TIMEOUT;
        end
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        bus.pwr_down_req = 1'b0;
        bus.pwr_up_req   = 1'b0;
        bus.PG_ack_signals = '0;
        bus.memory_ack   = 1'b0;
        #1;
        tl.delete();
        mile(cyc, 0, 0, 0, 0, 0, 0, 0);
        down_edge = -1; up_edge = -1;
        pg_on = NEVER; pg_off = NEVER; mem_on = NEVER; mem_off = NEVER;
        pg_low = '0; force_up_at_down = 1'b0;
        check();
        @(posedge hclk);
        cyc++;
        @(negedge hclk);
        reset = 1'b0;
        check();
    endtask

    initial begin
        int a, b, c, d;
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b1;
        bus.pwr_down_req = 1'b0;
        bus.pwr_up_req   = 1'b0;
        bus.data_valid   = 1'b0;
        bus.PG_ack_signals = '0;
        bus.memory_ack   = 1'b0;
        down_edge = -1; up_edge = -1;
        pg_on = NEVER; pg_off = NEVER; mem_on = NEVER; mem_off = NEVER;
        pg_low = '0; dv_at_down = 1'b0; force_up_at_down = 1'b0;
        mile(0, 0, 0, 0, 0, 0, 0, 0);
        tag = "reset";
        @(negedge hclk);
        @(negedge hclk);
        check();
        reset = 1'b0;
        step();

        tag = "down_basic";
        plan_down(1, 1);
        run_to_end(3);
        tag = "up_basic";
        plan_up(2, 2);
        run_to_end(2);

        tag = "down_dropped";
        down_edge = cyc + 1;
        dv_at_down = 1'b1;
        up_edge = cyc + 3;
        end_edge = cyc;
        run_to_end(6);
        tag = "down_after_drop";
        plan_down(3, 2);
        run_to_end(1);
        tag = "up_after_drop";
        plan_up(1, 4);
        run_to_end(2);

        tag = "pg_timeout";
        plan_down(TIMEOUT + 1, 1);
        run_to_end(10);
        tag = "err_reset";
        async_reset();
        step();

        tag = "partial_timeout";
        pg_low = 4'b0111;
        plan_down(NEVER, 1);
        run_to_end(4);
        async_reset();

        tag = "partial_ack_last";
        pg_low = 4'b0111;
        plan_down(TIMEOUT, TIMEOUT);
        run_to_end(2);
        pg_low = '0;
        tag = "up_ack_last";
        plan_up(TIMEOUT, TIMEOUT);
        run_to_end(2);

        tag = "mem_timeout";
        plan_down(2, TIMEOUT + 1);
        run_to_end(5);
        async_reset();

        tag = "reset_in_save";
        plan_down(5, 5);
        end_edge = down_edge + ISO_CYC;
        run_to_end(1);
        async_reset();
        step();

        tag = "down_up_together";
        force_up_at_down = 1'b1;
        plan_down(2, 3);
        run_to_end(2);
        force_up_at_down = 1'b0;
        plan_up(3, 3);
        run_to_end(1);

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("rand_down_%0d", i);
            a = $urandom_range(1, 12);
            b = $urandom_range(1, 12);
            c = $urandom_range(1, 12);
            d = $urandom_range(1, 12);
            force_up_at_down = 1'($urandom_range(0, 1));
            plan_down(a, b);
            run_to_end($urandom_range(0, 4));
            force_up_at_down = 1'b0;
            tag = $sformatf("rand_up_%0d", i);
            plan_up(c, d);
            run_to_end($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
